// File: rtl/smooth_pkg.sv
// Shared sizing, mode-clamp and rounding helpers for smooth_avg_ch.
// Optional build macro: SMOOTH_ROUND_EN selects round-half-up averaging instead of floor.
package smooth_pkg;

`ifdef SMOOTH_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   function automatic int unsigned sum_width(int unsigned dw, int unsigned max_log2);
      return dw + max_log2;
   endfunction

   function automatic int unsigned clamp_k(int unsigned mode, int unsigned max_log2);
      return (mode > max_log2) ? max_log2 : mode;
   endfunction

   // Half an LSB of the shifted result; zero for k = 0 or when flooring.
   function automatic int unsigned rnd_const(int unsigned k);
      return (RoundEn && k != 0) ? (32'd1 << (k - 1)) : 32'd0;
   endfunction

endpackage

// File: rtl/smooth_avg_ch_if.sv
// Sample/result bus of the moving-average smoother.
interface smooth_avg_ch_if #(
   parameter int unsigned DW       = 16,
   parameter int unsigned CH       = 2,
   parameter int unsigned MAX_LOG2 = 4
);
   localparam int unsigned KW = $clog2(MAX_LOG2 + 1);

   logic             v_sync;
   logic [KW-1:0]    mode;
   logic [CH*DW-1:0] in_data;
   logic [CH*DW-1:0] out_data;
   logic             out_valid;
   logic             out_settled;

   modport master (
      output v_sync, mode, in_data,
      input  out_data, out_valid, out_settled
   );

   modport slave (
      input  v_sync, mode, in_data,
      output out_data, out_valid, out_settled
   );
endinterface

// File: rtl/smooth_chan.sv
// One smoother channel: sample ring buffer, running window sum and registered output.
module smooth_chan
   import smooth_pkg::*;
#(
   parameter int unsigned DW       = 16,
   parameter int unsigned MAX_LOG2 = 4
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    stb_i,
   input  logic                                    flush_i,
   input  logic                                    drop_i,
   input  logic [MAX_LOG2-1:0]                     wr_ptr_i,
   input  logic [MAX_LOG2-1:0]                     rd_ptr_i,
   input  logic [DW-1:0]                           sample_i,
   input  logic                                    pend_i,
   input  logic                                    settled_i,
   input  logic [$clog2(MAX_LOG2+1)-1:0]           k_i,
   input  logic [sum_width(DW, MAX_LOG2)-1:0]      rnd_i,
   output logic [DW-1:0]                           out_o
);
   localparam int unsigned Depth = 2 ** MAX_LOG2;
   localparam int unsigned SW    = sum_width(DW, MAX_LOG2);

   logic [DW-1:0]        mem_q [Depth];
   logic signed [SW-1:0] sum_q, sum_d, new_ext, old_ext, rounded;
   logic [DW-1:0]        newest_q, out_q, out_d;

   assign new_ext = SW'($signed(sample_i));
   assign old_ext = SW'($signed(mem_q[rd_ptr_i]));

   always_ff @(posedge clk_i) begin
      if (stb_i) mem_q[wr_ptr_i] <= sample_i;
   end

   always_comb begin
      sum_d = sum_q;
      if (flush_i) begin
         sum_d = stb_i ? new_ext : '0;
      end else if (stb_i) begin
         sum_d = drop_i ? sum_q + new_ext - old_ext : sum_q + new_ext;
      end
      rounded = sum_q + $signed(rnd_i);
      out_d   = out_q;
      if (pend_i) out_d = settled_i ? DW'(rounded >>> k_i) : newest_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sum_q    <= '0;
         newest_q <= '0;
         out_q    <= '0;
      end else begin
         sum_q    <= sum_d;
         newest_q <= stb_i ? sample_i : newest_q;
         out_q    <= out_d;
      end
   end

   assign out_o = out_q;
endmodule

// File: rtl/smooth_avg_ch.sv
// Multi-channel 2^k moving-average smoother; owns strobe detect, write pointer, fill and flush.
// Optional build macro: SMOOTH_ROUND_EN (see smooth_pkg).
module smooth_avg_ch
   import smooth_pkg::*;
#(
   parameter int unsigned DW       = 16,
   parameter int unsigned CH       = 2,
   parameter int unsigned MAX_LOG2 = 4
) (
   input  logic            clk,
   input  logic            reset,
   smooth_avg_ch_if.slave  bus
);
   localparam int unsigned KW = $clog2(MAX_LOG2 + 1);
   localparam int unsigned FW = MAX_LOG2 + 1;
   localparam int unsigned SW = sum_width(DW, MAX_LOG2);

   logic                v_sync_q, stb, flush, full, drop;
   logic [KW-1:0]       k_clamp, k_q;
   logic [MAX_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr;
   logic [FW-1:0]       fill_q, fill_d, win_cur, win_new;
   logic                pend_q, pend_settled_q, pend_settled_d;
   logic                out_valid_q, out_settled_q, out_settled_d;
   logic [SW-1:0]       rnd;
   logic [DW-1:0]       ch_out [CH];

   assign k_clamp = KW'(clamp_k(32'(bus.mode), MAX_LOG2));
   assign stb     = bus.v_sync & ~v_sync_q & ~reset;
   assign flush   = k_clamp != k_q;
   assign win_cur = FW'(1) << k_q;
   assign win_new = FW'(1) << k_clamp;
   assign full    = fill_q == win_cur;
   assign drop    = full & ~flush;
   // For the maximum window the truncated offset is 0, so the oldest slot is wr_ptr itself.
   assign rd_ptr  = wr_ptr_q - win_cur[MAX_LOG2-1:0];
   assign rnd     = SW'(rnd_const(32'(k_q)));

   always_comb begin
      fill_d = fill_q;
      if (flush) begin
         fill_d = stb ? FW'(1) : '0;
      end else if (stb && !full) begin
         fill_d = fill_q + FW'(1);
      end
      wr_ptr_d       = stb ? wr_ptr_q + MAX_LOG2'(1) : wr_ptr_q;
      pend_settled_d = fill_d == win_new;
      out_settled_d  = out_settled_q;
      if (flush) begin
         out_settled_d = 1'b0;
      end else if (pend_q) begin
         out_settled_d = pend_settled_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_sync_q       <= 1'b1;
         k_q            <= k_clamp;
         wr_ptr_q       <= '0;
         fill_q         <= '0;
         pend_q         <= 1'b0;
         pend_settled_q <= 1'b0;
         out_valid_q    <= 1'b0;
         out_settled_q  <= 1'b0;
      end else begin
         v_sync_q       <= bus.v_sync;
         k_q            <= k_clamp;
         wr_ptr_q       <= wr_ptr_d;
         fill_q         <= fill_d;
         pend_q         <= stb;
         pend_settled_q <= pend_settled_d;
         out_valid_q    <= pend_q;
         out_settled_q  <= out_settled_d;
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_chan
      smooth_chan #(
         .DW       (DW),
         .MAX_LOG2 (MAX_LOG2)
      ) u_chan (
         .clk_i     (clk),
         .rst_i     (reset),
         .stb_i     (stb),
         .flush_i   (flush),
         .drop_i    (drop),
         .wr_ptr_i  (wr_ptr_q),
         .rd_ptr_i  (rd_ptr),
         .sample_i  (bus.in_data[c*DW +: DW]),
         .pend_i    (pend_q),
         .settled_i (pend_settled_q),
         .k_i       (k_q),
         .rnd_i     (rnd),
         .out_o     (ch_out[c])
      );
   end

   always_comb begin
      bus.out_data = '0;
      for (int c = 0; c < CH; c++) bus.out_data[c*DW +: DW] = ch_out[c];
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_settled = out_settled_q;
endmodule
